des_fp_serializer: RTL and testbench
====================================

// Module: des_fp_serializer
// PURPOSE
//  Output end of the DES datapath, and the counterpart of the input-side initial permutation.
//  - Accepts the round-16 halves L16/R16 from the round engine through a valid/ready handshake.
//  - Applies the final swap and the inverse initial permutation (IP^-1) to form the 64-bit result.
//  - Buffers results in a small FIFO and streams each one out MSB-first in BEAT_W-bit beats.
// PARAMETERS
//  BEAT_W  8  width of one output beat; must divide 64. BEATS = 64/BEAT_W.
//  DEPTH   2  result FIFO entries; power of 2, >= 2.
// PORTS
//  clk       in   1       sole clock; all state updates on rising edge
//  rst_n     in   1       reset, synchronous and active-low
//  in_valid  in   1       L16/R16 present
//  in_ready  out  1       block can accept; equals !fifo_full, registered, no input->ready path
//  in_l      in   [32:1]  L16, DES bit numbering (bit 1 = MSB)
//  in_r      in   [32:1]  R16, DES bit numbering
//  tx_valid  out  1       beat valid
//  tx_ready  in   1       sink accepts beat
//  tx_data   out  BEAT_W  current beat, DES bits [k*BEAT_W+1 : (k+1)*BEAT_W], k = beat index
//  tx_last   out  1       high on beat BEATS-1 of each block
//  busy      out  1       FIFO non-empty or state SEND
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): FIFO empty, state IDLE, beat index 0.
//   Outputs: in_ready=1 (from the first cycle after reset), tx_valid=0, tx_data=0, tx_last=0, busy=0.
//   Reset mid-block drops the partial block and all queued blocks; no further beats are emitted.
//  Transform: preout[1:32]=in_r, preout[33:64]=in_l (final swap).
//   Then out[i] = preout[FP[i]] with FP = 40 8 48 16 56 24 64 32, 39 7 47 15 55 23 63 31,
//   38 6 46 14 54 22 62 30, 37 5 45 13 53 21 61 29, 36 4 44 12 52 20 60 28,
//   35 3 43 11 51 19 59 27, 34 2 42 10 50 18 58 26, 33 1 41 9 49 17 57 25.
//   The FIFO stores the permuted 64-bit word.
//  Push: in_valid & in_ready at an edge writes the FIFO. in_valid while in_ready=0 is held off; data is not lost.
//  FSM IDLE:
//   - FIFO non-empty: pop the head into shift reg, k=0, go to SEND.
//   - Otherwise stay; tx_valid=0.
//  FSM SEND: tx_valid=1; tx_data=shift[MSB beat]; tx_last=(k==BEATS-1).
//   - tx_ready & !tx_last: shift left by BEAT_W, k++.
//   - tx_ready & tx_last, FIFO non-empty: pop and load the next word, k=0, stay in SEND (back-to-back, no bubble).
//   - tx_ready & tx_last, FIFO empty: go to IDLE.
//   - !tx_ready: tx_data, tx_last and k hold stable (AXI-style; valid never drops without a handshake).
//  Latency: accept at edge n -> pop at edge n+1 (if IDLE) -> first beat valid in cycle n+1..n+2.
//   In-to-first-beat latency = 2 edges.
//  Simultaneous push and pop in the same cycle are legal at any occupancy. in_ready is computed
//   from the registered count only, so a push is refused when full even if a pop happens that cycle.
//  Throughput: one beat per cycle while tx_ready=1. One block per BEATS cycles sustained.
//  Pointers are log2(DEPTH)-bit and wrap naturally; count is log2(DEPTH)+1 bits.
// STRUCTURE
//  des_pkg:
//   - localparam FP table [1:64].
//   - des_block_t = logic [64:1].
//   - des_half_t = logic [32:1].
//  Sub-module fp (combinational IP^-1, same bit numbering as the input permutation) is
//   instantiated once on the push path. FIFO and FSM are inline.
//  Assertions: BEAT_W divides 64; DEPTH is a power of 2.
// TESTING
//  1. Reset then push L16=43423234 R16=0A4CD995, tx_ready=1
//     -> beats 85 E8 13 54 0F 0A B4 05; tx_last on 05.
//  2. Round-trip: for random x, in_r=IP(x)[1:32], in_l=IP(x)[33:64] -> serialized output == x (1000 vectors).
//  3. Hold tx_ready=0: push DEPTH+1 blocks
//     -> in_ready=0 after DEPTH+1 accepts (1 in shift reg + DEPTH in FIFO); tx_data stable.
//     Release -> all blocks are emitted in order.
//  4. Two queued blocks, tx_ready=1 -> 16 consecutive valid beats, no gap; tx_last on beats 7 and 15.
//  5. Random tx_ready (50%) and in_valid (50%), 500 blocks vs scoreboard -> no loss, reorder or duplication.
//  6. rst_n=0 for 1 cycle at beat 3 of a block with 1 queued
//     -> next cycle tx_valid=0, busy=0, in_ready=1; the next pushed block is emitted from beat 0.

Source files
------------

// File: rtl/des_fp_serializer_pkg.sv
// Shared types and constants for the DES output stage: block/half types,
// the inverse initial permutation table and the serializer state encoding.
package des_fp_serializer_pkg;

    localparam int BLOCK_W = 64;
    localparam int HALF_W  = 32;

    // DES bit numbering: bit 1 is the MSB, so DES bit n lives at index n of these types
    // only by name; the MSB sits at the highest index.
    typedef logic [BLOCK_W:1] des_block_t;
    typedef logic [HALF_W:1]  des_half_t;

    // Inverse initial permutation: output DES bit i takes pre-output DES bit FP[i].
    localparam int FP [1:64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    // Serializer states: nothing loaded, or a block sitting in the shift register.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Converts a DES bit number (1 = MSB) into the vector index of a des_block_t.
    function automatic int des_index(input int des_bit);
        return BLOCK_W + 1 - des_bit;
    endfunction

endpackage

// File: rtl/des_fp_serializer_if.sv
// Bus bundle for the DES output stage: the round-engine handshake on the
// input side and the beat stream on the output side.
interface des_fp_serializer_if
    import des_fp_serializer_pkg::*;
#(
    parameter int BEAT_W = 8
);

    logic              in_valid;
    logic              in_ready;
    des_half_t         in_l;
    des_half_t         in_r;
    logic              tx_valid;
    logic              tx_ready;
    logic [BEAT_W-1:0] tx_data;
    logic              tx_last;
    logic              busy;

    // The side that produces halves and consumes beats.
    modport master (
        output in_valid,
        output in_l,
        output in_r,
        output tx_ready,
        input  in_ready,
        input  tx_valid,
        input  tx_data,
        input  tx_last,
        input  busy
    );

    // The serializer itself.
    modport slave (
        input  in_valid,
        input  in_l,
        input  in_r,
        input  tx_ready,
        output in_ready,
        output tx_valid,
        output tx_data,
        output tx_last,
        output busy
    );

endinterface

// File: rtl/des_fp_serializer_fp.sv
// Combinational final swap plus inverse initial permutation (IP^-1).
// Uses the same DES bit numbering as the input-side initial permutation.
module des_fp_serializer_fp
    import des_fp_serializer_pkg::*;
(
    input  des_half_t  l16,
    input  des_half_t  r16,
    output des_block_t block_out
);

    des_block_t preout;

    // The final swap puts R16 in DES bits 1..32 and L16 in bits 33..64.
    assign preout = {r16, l16};

    // Pure wiring: each output bit picks one pre-output bit through the FP table.
    for (genvar i = 1; i <= BLOCK_W; i++) begin : g_fp_bit
        assign block_out[des_index(i)] = preout[des_index(FP[i])];
    end

endmodule

// File: rtl/des_fp_serializer.sv
// DES output stage: permutes each accepted L16/R16 pair into the final
// 64-bit result, queues it in a small FIFO and streams it out MSB-first
// in BEAT_W-bit beats with a valid/ready handshake.
module des_fp_serializer
    import des_fp_serializer_pkg::*;
#(
    parameter int BEAT_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    des_fp_serializer_if.slave bus
);

    localparam int BEATS      = BLOCK_W / BEAT_W;
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W      = PTR_W + 1;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((BLOCK_W % BEAT_W) != 0) begin : g_beat_w_check
        $error("des_fp_serializer: BEAT_W must divide 64");
    end

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("des_fp_serializer: DEPTH must be a power of 2 and at least 2");
    end

    // Result FIFO storage and bookkeeping.
    des_block_t             mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    // Serializer datapath.
    des_block_t             fp_word;
    des_block_t             shift_q;
    logic [BEAT_CNT_W-1:0]  beat_q;
    logic                   last_beat;
    logic                   advance;
    state_t                 state_q;
    state_t                 state_d;

    des_fp_serializer_fp u_fp (
        .l16       (bus.in_l),
        .r16       (bus.in_r),
        .block_out (fp_word)
    );

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CNT_W'(DEPTH));
    assign bus.in_ready = !fifo_full;
    assign push         = bus.in_valid && !fifo_full;
    assign last_beat    = (beat_q == BEAT_CNT_W'(BEATS - 1));

    // Write the permuted word into the FIFO on every accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fp_word;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide at any fill level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register and beat index: load on pop, otherwise step one beat per accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            beat_q  <= '0;
        end else if (pop) begin
            shift_q <= mem[rd_ptr];
            beat_q  <= '0;
        end else if (advance) begin
            shift_q <= shift_q << BEAT_W;
            beat_q  <= beat_q + BEAT_CNT_W'(1);
        end
    end

    // Next state, FIFO pop and beat advance, plus the beat-side outputs.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        advance      = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_last  = 1'b0;
        bus.busy     = !fifo_empty;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = shift_q[BLOCK_W -: BEAT_W];
                bus.tx_last  = last_beat;
                bus.busy     = 1'b1;
                if (bus.tx_ready) begin
                    if (!last_beat) begin
                        advance = 1'b1;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_des_fp_serializer.sv
// Directed and randomized checks for the DES output serializer.
module tb_des_fp_serializer;
    import des_fp_serializer_pkg::*;

    localparam int BEAT_W  = 8;
    localparam int DEPTH   = 2;
    localparam int BEATS   = 64 / BEAT_W;
    localparam int N_ROUND = 1000;
    localparam int N_RAND  = 500;

    // Forward initial permutation, used to build round-trip stimulus.
    localparam int IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    des_fp_serializer_if #(.BEAT_W(BEAT_W)) bus ();

    des_fp_serializer #(.BEAT_W(BEAT_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            y[63 - i] = x[64 - IP_TAB[i]];
        end
        return y;
    endfunction

    // One bus cycle, entered and left at posedge+1: drive inputs, report what the DUT shows
    // this cycle and whether the push will be taken at the coming edge.
    task automatic drive_cycle(input logic iv, input des_half_t l_in, input des_half_t r_in,
                               input logic tr, output logic pushed, output logic v,
                               output logic [BEAT_W-1:0] d, output logic last);
        bus.in_valid = iv;
        bus.in_l     = l_in;
        bus.in_r     = r_in;
        bus.tx_ready = tr;
        pushed       = iv && bus.in_ready;
        v            = bus.tx_valid;
        d            = bus.tx_data;
        last         = bus.tx_last;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_l     = '0;
        bus.in_r     = '0;
        bus.tx_ready = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", bus.tx_valid);
        end
        n_checks++;
        if (bus.tx_data !== 8'h00) begin
            n_fail++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data);
        end
        n_checks++;
        if (bus.tx_last !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_tx_last: got %b expected 0", bus.tx_last);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got valid=%b busy=%b ready=%b expected 0 0 1",
                     bus.tx_valid, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_known_vector();
        logic [63:0]       exp_word = 64'h85E813540F0AB405;
        logic              p, v, l;
        logic [BEAT_W-1:0] d;
        int                beats = 0;
        int                cyc   = 0;
        int                first = -1;
        drive_cycle(1'b1, 32'h43423234, 32'h0A4CD995, 1'b1, p, v, d, l);
        n_checks++;
        if (p !== 1'b1) begin
            n_fail++; $display("[TB] FAIL known_push: got %b expected 1", p);
        end
        while (beats < BEATS && cyc < 40) begin
            drive_cycle(1'b0, '0, '0, 1'b1, p, v, d, l);
            cyc++;
            if (v) begin
                if (first < 0) first = cyc;
                n_checks++;
                if (d !== exp_word[63 - BEAT_W*beats -: BEAT_W]) begin
                    n_fail++;
                    $display("[TB] FAIL known_beat%0d: got %h expected %h", beats, d,
                             exp_word[63 - BEAT_W*beats -: BEAT_W]);
                end
                n_checks++;
                if (l !== (beats == BEATS - 1)) begin
                    n_fail++;
                    $display("[TB] FAIL known_last%0d: got %b expected %b", beats, l, beats == BEATS - 1);
                end
                beats++;
            end
        end
        n_checks++;
        if (beats != BEATS) begin
            n_fail++; $display("[TB] FAIL known_beat_count: got %0d expected %0d", beats, BEATS);
        end
        n_checks++;
        if (first != 2) begin
            n_fail++; $display("[TB] FAIL known_latency: got %0d expected 2", first);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]       xs [4] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                      64'h00FF00FF55AA55AA, 64'hC3C3A5A5F00F0FF0};
        logic [63:0]       y, word;
        logic              p, v, l;
        logic [BEAT_W-1:0] d;
        logic [BEAT_W-1:0] held = '0;
        logic              seen = 1'b0;
        int                acc = 0, got = 0, idx = 0, cyc = 0, stable_err = 0;
        word = '0;
        for (int c = 0; c < 12; c++) begin
            y = ip(xs[acc < 4 ? acc : 3]);
            drive_cycle(acc < 4, y[31:0], y[63:32], 1'b0, p, v, d, l);
            if (p) acc++;
            if (bus.tx_valid) begin
                if (!seen) begin
                    held = bus.tx_data;
                    seen = 1'b1;
                end else if (bus.tx_data !== held) begin
                    stable_err++;
                end
            end
        end
        n_checks++;
        if (acc != DEPTH + 1) begin
            n_fail++; $display("[TB] FAIL hold_accepts: got %0d expected %0d", acc, DEPTH + 1);
        end
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("[TB] FAIL hold_in_ready: got %b expected 0", bus.in_ready);
        end
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hold_valid_busy: got %b %b expected 1 1", bus.tx_valid, bus.busy);
        end
        n_checks++;
        if (held !== 8'h01 || stable_err != 0) begin
            n_fail++;
            $display("[TB] FAIL hold_tx_data: got %h (%0d changes) expected 01 stable", held, stable_err);
        end
        while (got < 4 && cyc < 100) begin
            y = ip(xs[acc < 4 ? acc : 3]);
            drive_cycle(acc < 4, y[31:0], y[63:32], 1'b1, p, v, d, l);
            cyc++;
            if (p) acc++;
            if (v) begin
                word = {word[63-BEAT_W:0], d};
                idx++;
                if (idx == BEATS) begin
                    n_checks++;
                    if (word !== xs[got]) begin
                        n_fail++;
                        $display("[TB] FAIL hold_order%0d: got %h expected %h", got, word, xs[got]);
                    end
                    got++;
                    idx = 0;
                end
            end
        end
        n_checks++;
        if (got != 4) begin
            n_fail++; $display("[TB] FAIL hold_drain: got %0d blocks expected 4", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0]      ab = {64'h1122334455667788, 64'h99AABBCCDDEEFF00};
        logic [63:0]       y;
        logic              p, v, l;
        logic [BEAT_W-1:0] d;
        y = ip(ab[127:64]);
        drive_cycle(1'b1, y[31:0], y[63:32], 1'b0, p, v, d, l);
        n_checks++;
        if (p !== 1'b1) begin
            n_fail++; $display("[TB] FAIL b2b_push0: got %b expected 1", p);
        end
        y = ip(ab[63:0]);
        drive_cycle(1'b1, y[31:0], y[63:32], 1'b0, p, v, d, l);
        n_checks++;
        if (p !== 1'b1) begin
            n_fail++; $display("[TB] FAIL b2b_push1: got %b expected 1", p);
        end
        for (int i = 0; i < 2*BEATS; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, p, v, d, l);
            n_checks++;
            if (v !== 1'b1 || d !== ab[127 - BEAT_W*i -: BEAT_W] ||
                l !== (i == BEATS - 1 || i == 2*BEATS - 1)) begin
                n_fail++;
                $display("[TB] FAIL b2b_beat%0d: got v=%b d=%h last=%b expected 1 %h %b", i, v, d, l,
                         ab[127 - BEAT_W*i -: BEAT_W], (i == BEATS - 1 || i == 2*BEATS - 1));
            end
        end
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle: got valid=%b busy=%b expected 0 0", bus.tx_valid, bus.busy);
        end
    endtask

    task automatic test_round_trip();
        logic [63:0]       q [$];
        logic [63:0]       x, y, word, exp_w;
        logic              p, v, l;
        logic [BEAT_W-1:0] d;
        logic              lerr = 1'b0;
        int                sent = 0, got = 0, idx = 0, cyc = 0;
        word = '0;
        x = {$urandom, $urandom};
        while (got < N_ROUND && cyc < N_ROUND*BEATS*4) begin
            y = ip(x);
            drive_cycle(sent < N_ROUND, y[31:0], y[63:32], 1'b1, p, v, d, l);
            cyc++;
            if (p) begin
                q.push_back(x);
                sent++;
                x = {$urandom, $urandom};
            end
            if (v) begin
                word = {word[63-BEAT_W:0], d};
                if (l !== (idx == BEATS - 1)) lerr = 1'b1;
                idx++;
                if (idx == BEATS) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++; $display("[TB] FAIL round_trip_extra: got %h expected nothing", word);
                    end else begin
                        exp_w = q.pop_front();
                        if (word !== exp_w || lerr) begin
                            n_fail++;
                            $display("[TB] FAIL round_trip%0d: got %h last_err=%b expected %h 0",
                                     got, word, lerr, exp_w);
                        end
                    end
                    got++;
                    idx  = 0;
                    lerr = 1'b0;
                end
            end
        end
        n_checks++;
        if (got != N_ROUND) begin
            n_fail++; $display("[TB] FAIL round_trip_count: got %0d expected %0d", got, N_ROUND);
        end
    endtask

    task automatic test_random_stream();
        logic [63:0]       q [$];
        logic [63:0]       x, y, word, exp_w;
        logic              p, v, l, iv, tr;
        logic [BEAT_W-1:0] d;
        logic              pv = 1'b0, ptr = 1'b0, pl = 1'b0;
        logic [BEAT_W-1:0] pd = '0;
        logic              lerr = 1'b0;
        int                sent = 0, got = 0, idx = 0, cyc = 0, stall_err = 0;
        word = '0;
        x = {$urandom, $urandom};
        while (got < N_RAND && cyc < N_RAND*BEATS*6) begin
            y  = ip(x);
            iv = (sent < N_RAND) && ($urandom_range(0, 1) == 1);
            tr = ($urandom_range(0, 1) == 1);
            drive_cycle(iv, y[31:0], y[63:32], tr, p, v, d, l);
            cyc++;
            if (pv && !ptr && (!v || d !== pd || l !== pl)) stall_err++;
            pv  = v;
            ptr = tr;
            pd  = d;
            pl  = l;
            if (p) begin
                q.push_back(x);
                sent++;
                x = {$urandom, $urandom};
            end
            if (v && tr) begin
                word = {word[63-BEAT_W:0], d};
                if (l !== (idx == BEATS - 1)) lerr = 1'b1;
                idx++;
                if (idx == BEATS) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_fail++; $display("[TB] FAIL random_extra: got %h expected nothing", word);
                    end else begin
                        exp_w = q.pop_front();
                        if (word !== exp_w || lerr) begin
                            n_fail++;
                            $display("[TB] FAIL random_block%0d: got %h last_err=%b expected %h 0",
                                     got, word, lerr, exp_w);
                        end
                    end
                    got++;
                    idx  = 0;
                    lerr = 1'b0;
                end
            end
        end
        n_checks++;
        if (got != N_RAND) begin
            n_fail++; $display("[TB] FAIL random_count: got %0d expected %0d", got, N_RAND);
        end
        n_checks++;
        if (stall_err != 0) begin
            n_fail++; $display("[TB] FAIL random_stall_hold: got %0d changes expected 0", stall_err);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [63:0]       xa = 64'hA1A2A3A4A5A6A7A8;
        logic [63:0]       xb = 64'hB1B2B3B4B5B6B7B8;
        logic [63:0]       xc = 64'h0F1E2D3C4B5A6978;
        logic [63:0]       y, word;
        logic              p, v, l;
        logic [BEAT_W-1:0] d;
        logic [BEAT_W-1:0] first_d = '0;
        int                beats = 0;
        word = '0;
        y = ip(xa);
        drive_cycle(1'b1, y[31:0], y[63:32], 1'b0, p, v, d, l);
        y = ip(xb);
        drive_cycle(1'b1, y[31:0], y[63:32], 1'b0, p, v, d, l);
        repeat (3) drive_cycle(1'b0, '0, '0, 1'b1, p, v, d, l);
        n_checks++;
        if (bus.tx_data !== xa[39:32] || bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midrst_pre: got data=%h busy=%b expected %h 1", bus.tx_data, bus.busy, xa[39:32]);
        end
        rst_n = 1'b0;
        drive_cycle(1'b0, '0, '0, 1'b0, p, v, d, l);
        rst_n = 1'b1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.tx_data !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midrst_post: got valid=%b busy=%b ready=%b data=%h expected 0 0 1 00",
                     bus.tx_valid, bus.busy, bus.in_ready, bus.tx_data);
        end
        y = ip(xc);
        drive_cycle(1'b1, y[31:0], y[63:32], 1'b1, p, v, d, l);
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, p, v, d, l);
            if (v) begin
                if (beats == 0) first_d = d;
                word = {word[63-BEAT_W:0], d};
                beats++;
            end
        end
        n_checks++;
        if (first_d !== xc[63:56]) begin
            n_fail++; $display("[TB] FAIL midrst_first_beat: got %h expected %h", first_d, xc[63:56]);
        end
        n_checks++;
        if (beats != BEATS || word !== xc) begin
            n_fail++;
            $display("[TB] FAIL midrst_block: got %0d beats word %h expected %0d beats %h", beats, word, BEATS, xc);
        end
    endtask

    initial begin
        $display("[TB] starting des_fp_serializer tests");
        test_reset();
        test_known_vector();
        test_backpressure();
        test_back_to_back();
        test_round_trip();
        test_random_stream();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
